// File: rtl/axil_pkg.sv
// axil_pkg: shared types for the exclusive-access AXI4-Lite memory slave.
//   excl_op_t   - sideband operation code carried with AW/AR
//   RESP_*      - AXI response encodings
//   w_state_t   - write FSM states
//   r_state_t   - read FSM states
package axil_pkg;

  typedef enum logic [1:0] {
    EXCL_NONE = 2'd0,
    EXCL_LR   = 2'd1,
    EXCL_SC   = 2'd2
  } excl_op_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_READ = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

endpackage

// File: rtl/axil_reservation_table.sv
// axil_reservation_table: one {valid, word index} reservation per master.
// Ports:
//   clk, reset_n           - clock, async active-low reset (all entries invalid)
//   set_en/set_id/set_idx  - LR: load entry[set_id] with set_idx
//   sc_en/sc_id/sc_idx     - SC: sc_ok reports whether entry[sc_id] holds sc_idx;
//                            sc_en clears entry[sc_id] regardless of outcome
//   clr_en/clr_idx         - committed write: clear every entry holding clr_idx
// The read FSM stalls during a write commit, so set never coincides with sc/clr.
module axil_reservation_table
  import axil_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ID_W      = 2,
  parameter int IDX_W     = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_en,
  input  logic [ID_W-1:0]  set_id,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             sc_en,
  input  logic [ID_W-1:0]  sc_id,
  input  logic [IDX_W-1:0] sc_idx,
  output logic             sc_ok,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  logic [NUM_CORES-1:0]            vld;
  logic [NUM_CORES-1:0][IDX_W-1:0] idx;

  assign sc_ok = vld[sc_id] && (idx[sc_id] == sc_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      idx <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if ((clr_en && vld[i] && (idx[i] == clr_idx)) ||
            (sc_en && (sc_id == ID_W'(i))))
          vld[i] <= 1'b0;
        // A new LR simply overwrites whatever the master held before.
        if (set_en && (set_id == ID_W'(i))) begin
          vld[i] <= 1'b1;
          idx[i] <= set_idx;
        end
      end
    end
  end

endmodule

// File: rtl/axil_excl_mem_slave.sv
// axil_excl_mem_slave: AXI4-Lite slave over a word-addressed RAM with LR/SC.
// Ports:
//   clk, reset_n                    - clock, async active-low reset
//   s_axi_aw*/w*/b*                 - write address/data/response channels
//   s_axi_ar*/r*                    - read address/data channels
//   s_axi_aw_excl_op, s_axi_aw_id   - SC marker and master id, taken with AW
//   s_axi_ar_excl_op, s_axi_ar_id   - LR marker and master id, taken with AR
// Independent write (IDLE->COMMIT->RESP) and read (IDLE->READ->RESP) FSMs share
// one RAM port; the write commit wins and the read waits in R_READ.
module axil_excl_mem_slave
  import axil_pkg::*;
#(
  parameter int          NUM_CORES       = 4,
  parameter int          MASTER_ID_WIDTH = $clog2(NUM_CORES),
  parameter int          MEM_WORDS       = 4096,
  parameter logic [31:0] ADDR_BASE       = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                s_axi_awaddr,
  input  logic [2:0]                 s_axi_awprot,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [31:0]                s_axi_wdata,
  input  logic [3:0]                 s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [31:0]                s_axi_araddr,
  input  logic [2:0]                 s_axi_arprot,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [31:0]                s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  input  logic [1:0]                 s_axi_aw_excl_op,
  input  logic [MASTER_ID_WIDTH-1:0] s_axi_aw_id,
  input  logic [1:0]                 s_axi_ar_excl_op,
  input  logic [MASTER_ID_WIDTH-1:0] s_axi_ar_id
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  // Address decode: offset from base, word index, range check.
  logic [31:0] aw_off, ar_off;
  assign aw_off = s_axi_awaddr - ADDR_BASE;
  assign ar_off = s_axi_araddr - ADDR_BASE;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, aw_off[1:0], ar_off[1:0]};

  // ---------------- write side ----------------
  w_state_t                   w_state;
  logic                       aw_cap, w_cap;
  logic                       aw_inr_q, aw_sc_q;
  logic [IDX_W-1:0]           aw_idx_q;
  logic [MASTER_ID_WIDTH-1:0] aw_id_q;
  logic [31:0]                wdata_q;
  logic [3:0]                 wstrb_q;
  logic [1:0]                 bresp_q;

  logic aw_hs, w_hs;
  assign s_axi_awready = reset_n && (w_state == W_IDLE) && !aw_cap;
  assign s_axi_wready  = reset_n && (w_state == W_IDLE) && !w_cap;
  assign aw_hs         = s_axi_awvalid && s_axi_awready;
  assign w_hs          = s_axi_wvalid  && s_axi_wready;

  // Commit decode: RAM write enable, reservation updates, response code.
  logic       commit, ram_we, res_clr, res_sc, sc_ok;
  logic [1:0] wr_resp;

  always_comb begin
    commit  = (w_state == W_COMMIT);
    ram_we  = 1'b0;
    res_clr = 1'b0;
    res_sc  = 1'b0;
    wr_resp = RESP_OKAY;
    if (commit) begin
      if (!aw_inr_q) begin
        wr_resp = RESP_SLVERR;          // out of range: nothing touched
      end else if (aw_sc_q) begin
        res_sc = 1'b1;                  // an SC always consumes its reservation
        if (sc_ok) begin
          ram_we  = 1'b1;
          res_clr = 1'b1;
          wr_resp = RESP_EXOKAY;
        end
      end else begin
        ram_we  = 1'b1;
        res_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state  <= W_IDLE;
      aw_cap   <= 1'b0;
      w_cap    <= 1'b0;
      aw_inr_q <= 1'b0;
      aw_sc_q  <= 1'b0;
      aw_idx_q <= '0;
      aw_id_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_cap   <= 1'b1;
            aw_inr_q <= (aw_off < MEM_BYTES);
            aw_idx_q <= aw_off[IDX_W+1:2];
            aw_sc_q  <= (s_axi_aw_excl_op == EXCL_SC);
            aw_id_q  <= s_axi_aw_id;
          end
          if (w_hs) begin
            w_cap   <= 1'b1;
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
          end
          // Both halves held (possibly arriving this very cycle): commit next.
          if ((aw_cap || aw_hs) && (w_cap || w_hs)) begin
            w_state <= W_COMMIT;
            aw_cap  <= 1'b0;
            w_cap   <= 1'b0;
          end
        end
        W_COMMIT: begin
          bresp_q <= wr_resp;
          w_state <= W_RESP;
        end
        W_RESP: if (s_axi_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign s_axi_bvalid = (w_state == W_RESP);
  assign s_axi_bresp  = s_axi_bvalid ? bresp_q : 2'b00;

  // ---------------- read side ----------------
  r_state_t                   r_state;
  logic                       ar_inr_q, ar_lr_q;
  logic [IDX_W-1:0]           ar_idx_q;
  logic [MASTER_ID_WIDTH-1:0] ar_id_q;
  logic [1:0]                 rresp_q;

  logic rd_go, ram_re, res_set;
  assign s_axi_arready = reset_n && (r_state == R_IDLE);
  assign rd_go         = (r_state == R_READ) && !commit;  // yield port to commit
  assign ram_re        = rd_go && ar_inr_q;
  assign res_set       = ram_re && ar_lr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= R_IDLE;
      ar_inr_q <= 1'b0;
      ar_lr_q  <= 1'b0;
      ar_idx_q <= '0;
      ar_id_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (s_axi_arvalid) begin
          ar_inr_q <= (ar_off < MEM_BYTES);
          ar_idx_q <= ar_off[IDX_W+1:2];
          ar_lr_q  <= (s_axi_ar_excl_op == EXCL_LR);
          ar_id_q  <= s_axi_ar_id;
          r_state  <= R_READ;
        end
        R_READ: if (rd_go) begin
          rresp_q <= ar_inr_q ? RESP_OKAY : RESP_SLVERR;
          r_state <= R_RESP;
        end
        R_RESP: if (s_axi_rready) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- RAM (no reset) ----------------
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] ram_q;

  always_ff @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (wstrb_q[b]) mem[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    if (ram_re) ram_q <= mem[ar_idx_q];
  end

  assign s_axi_rvalid = (r_state == R_RESP);
  assign s_axi_rresp  = s_axi_rvalid ? rresp_q : 2'b00;
  assign s_axi_rdata  = (s_axi_rvalid && ar_inr_q) ? ram_q : 32'h0;

  // ---------------- reservations ----------------
  axil_reservation_table #(
    .NUM_CORES (NUM_CORES),
    .ID_W      (MASTER_ID_WIDTH),
    .IDX_W     (IDX_W)
  ) u_resv (
    .clk     (clk),
    .reset_n (reset_n),
    .set_en  (res_set),
    .set_id  (ar_id_q),
    .set_idx (ar_idx_q),
    .sc_en   (res_sc),
    .sc_id   (aw_id_q),
    .sc_idx  (aw_idx_q),
    .sc_ok   (sc_ok),
    .clr_en  (res_clr),
    .clr_idx (aw_idx_q)
  );

endmodule

// File: tb/tb_axil_excl_mem_slave.sv
// Directed bench for axil_excl_mem_slave: inputs driven and outputs sampled
// on the falling edge, DUT acts on the rising edge.
module tb_axil_excl_mem_slave;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [1:0]  s_axi_aw_excl_op = '0;
  logic [1:0]  s_axi_aw_id = '0;
  logic [1:0]  s_axi_ar_excl_op = '0;
  logic [1:0]  s_axi_ar_id = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axil_excl_mem_slave dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_aw_excl_op(s_axi_aw_excl_op), .s_axi_aw_id(s_axi_aw_id),
    .s_axi_ar_excl_op(s_axi_ar_excl_op), .s_axi_ar_id(s_axi_ar_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write with per-channel start delays; optional B hold; optionally stop
  // once bvalid is seen without completing the B handshake.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] op,
                           input logic [1:0] id, input int aw_dly, input int w_dly,
                           input int hold, input bit stop_at_b,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int cyc = 0, lat = 0;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_aw_excl_op = op; s_axi_aw_id = id;
    s_axi_wdata = data;  s_axi_wstrb = strb;
    while (!(aw_done && w_done) && cyc < 100) begin
      s_axi_awvalid = !aw_done && (cyc >= aw_dly);
      s_axi_wvalid  = !w_done  && (cyc >= w_dly);
      if (w_done && !aw_done) chk("wready_after_w", {31'b0, s_axi_wready}, 32'd0);
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid  && s_axi_wready;
      @(posedge clk);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done  = 1;
      @(negedge clk);
      cyc++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    if (!(aw_done && w_done)) chk("wr_hs_timeout", 32'd0, 32'd1);
    while (!s_axi_bvalid && lat < 20) begin @(negedge clk); lat++; end
    chk("wr_latency", lat, 32'd1);
    resp = s_axi_bresp;
    if (stop_at_b) return;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bvalid_hold", {31'b0, s_axi_bvalid}, 32'd1);
      chk("bresp_hold", {30'b0, s_axi_bresp}, {30'b0, resp});
    end
    s_axi_bready = 1;
    @(posedge clk);
    @(negedge clk);
    s_axi_bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [1:0] op,
                          input logic [1:0] id, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int cyc = 0, lat = 0;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_ar_excl_op = op; s_axi_ar_id = id;
    s_axi_arvalid = 1;
    while (!s_axi_arready && cyc < 100) begin @(negedge clk); cyc++; end
    if (!s_axi_arready) chk("rd_hs_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_axi_arvalid = 0;
    while (!s_axi_rvalid && lat < 20) begin @(negedge clk); lat++; end
    chk("rd_latency", lat, 32'd1);
    data = s_axi_rdata; resp = s_axi_rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rvalid_hold", {31'b0, s_axi_rvalid}, 32'd1);
      chk("rdata_hold", s_axi_rdata, data);
      chk("rresp_hold", {30'b0, s_axi_rresp}, {30'b0, resp});
    end
    s_axi_rready = 1;
    @(posedge clk);
    @(negedge clk);
    s_axi_rready = 0;
  endtask

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd;

    // Reset: outputs quiet while low, readies up on the first cycle after.
    #1 reset_n = 0;
    #12;
    chk("rst_awready", {31'b0, s_axi_awready}, 32'd0);
    chk("rst_wready",  {31'b0, s_axi_wready},  32'd0);
    chk("rst_arready", {31'b0, s_axi_arready}, 32'd0);
    chk("rst_bvalid",  {31'b0, s_axi_bvalid},  32'd0);
    chk("rst_rvalid",  {31'b0, s_axi_rvalid},  32'd0);
    chk("rst_rdata",   s_axi_rdata,            32'd0);
    @(negedge clk); reset_n = 1;
    #1;
    chk("post_rst_ready", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

    // Full-word write, W leading AW by 3 cycles.
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 2'd0, 2'd0, 3, 0, 0, 0, br);
    chk("wr10_bresp", {30'b0, br}, {30'b0, RESP_OKAY});
    axi_read(32'h10, 2'd0, 2'd0, 0, rd, rr);
    chk("rd10_data", rd, 32'hDEAD_BEEF);
    chk("rd10_rresp", {30'b0, rr}, {30'b0, RESP_OKAY});

    // Byte-lane merge; AW leads W by 2 this time.
    axi_write(32'h20, 32'h1122_3344, 4'hF, 2'd0, 2'd0, 0, 2, 0, 0, br);
    axi_write(32'h20, 32'h0000_AA00, 4'b0010, 2'd0, 2'd0, 0, 0, 0, 0, br);
    axi_read(32'h20, 2'd0, 2'd0, 0, rd, rr);
    chk("rd20_merge", rd, 32'h1122_AA44);

    // Master 1 LR/SC succeeds once, second SC fails.
    axi_read(32'h40, EXCL_LR, 2'd1, 0, rd, rr);
    axi_write(32'h40, 32'd5, 4'hF, EXCL_SC, 2'd1, 0, 0, 0, 0, br);
    chk("sc1_exokay", {30'b0, br}, {30'b0, RESP_EXOKAY});
    axi_read(32'h40, 2'd0, 2'd0, 0, rd, rr);
    chk("sc1_mem", rd, 32'd5);
    axi_write(32'h40, 32'd6, 4'hF, EXCL_SC, 2'd1, 0, 0, 0, 0, br);
    chk("sc1b_okay", {30'b0, br}, {30'b0, RESP_OKAY});
    axi_read(32'h40, 2'd0, 2'd0, 0, rd, rr);
    chk("sc1b_mem", rd, 32'd5);

    // Another master's normal write breaks master 0's reservation.
    axi_read(32'h40, EXCL_LR, 2'd0, 0, rd, rr);
    axi_write(32'h40, 32'd7, 4'hF, 2'd0, 2'd2, 0, 0, 0, 0, br);
    axi_write(32'h40, 32'd9, 4'hF, EXCL_SC, 2'd0, 0, 0, 0, 0, br);
    chk("sc0_fail", {30'b0, br}, {30'b0, RESP_OKAY});
    axi_read(32'h40, 2'd0, 2'd0, 0, rd, rr);
    chk("sc0_mem", rd, 32'd7);

    // Out of range: SLVERR with held responses; reservation of master 1 on
    // 0x44 must survive a write aliasing its index and an out-of-range LR.
    axi_write(32'h44, 32'h12, 4'hF, 2'd0, 2'd0, 0, 0, 0, 0, br);
    axi_read(32'h44, EXCL_LR, 2'd1, 0, rd, rr);
    axi_write(32'h4044, 32'hFFFF_FFFF, 4'hF, 2'd0, 2'd2, 0, 0, 5, 0, br);
    chk("oor_bresp", {30'b0, br}, {30'b0, RESP_SLVERR});
    axi_read(32'h4000, EXCL_LR, 2'd1, 5, rd, rr);
    chk("oor_rresp", {30'b0, rr}, {30'b0, RESP_SLVERR});
    chk("oor_rdata", rd, 32'd0);
    axi_write(32'h44, 32'h34, 4'hF, EXCL_SC, 2'd1, 0, 0, 0, 0, br);
    chk("oor_resv_kept", {30'b0, br}, {30'b0, RESP_EXOKAY});
    axi_read(32'h44, 2'd0, 2'd0, 0, rd, rr);
    chk("rd44", rd, 32'h34);

    // Reset while B is pending drops it and all reservations.
    axi_write(32'h80, 32'h55, 4'hF, 2'd0, 2'd3, 0, 0, 0, 0, br);
    axi_read(32'h80, EXCL_LR, 2'd3, 0, rd, rr);
    axi_write(32'h84, 32'h66, 4'hF, 2'd0, 2'd0, 0, 0, 0, 1, br);
    chk("pre_rst_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
    chk("mid_rst_bresp",  {30'b0, s_axi_bresp},  32'd0);
    chk("mid_rst_ready",  {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    @(negedge clk);
    @(negedge clk); reset_n = 1;
    #1;
    chk("rel_ready",  {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
    chk("rel_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
    axi_write(32'h80, 32'h99, 4'hF, EXCL_SC, 2'd3, 0, 0, 0, 0, br);
    chk("post_rst_sc", {30'b0, br}, {30'b0, RESP_OKAY});
    axi_read(32'h80, 2'd0, 2'd0, 0, rd, rr);
    chk("post_rst_mem", rd, 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
